param_cache_control: RTL and testbench

PARAM_CACHE_CONTROL -- requirements
Module: param_cache_control

---
 rtl/lc3b_types_pkg.sv | 43 ++++
 rtl/param_cache_control_plru_tree.sv | 19 +
 rtl/param_cache_control.sv | 139 +++++++++++++
 tb/tb_param_cache_control.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types_pkg.sv
// lc3b_types: shared cache-controller state encoding and tree-PLRU helpers.
// Trees are held in a 15-bit vector, which covers up to 16 ways. Node 0 is the root.
// Node i has children 2i+1 (lower half) and 2i+2 (upper half).
// A node bit of 0 steers the victim walk into the lower half.
package lc3b_types;

    typedef enum logic [2:0] {IDLE, HOLD, WRITE_BACK, FETCH, WRITE_THRU} cache_state_t;

    localparam int PLRU_MAX_LVLS = 4;

    // Follow the node bits from the root down to a leaf.
    function automatic logic [3:0] plru_victim(input logic [14:0] bits, input int lvls);
        logic [3:0] idx;
        logic [3:0] node;
        idx  = '0;
        node = '0;
        for (int l = 0; l < PLRU_MAX_LVLS; l++)
            if (l < lvls) begin
                idx  = {idx[2:0], bits[node]};
                node = {node[2:0], 1'b0} + 4'd1 + {3'b0, bits[node]};
            end
        return idx;
    endfunction

    // Set every node on the accessed way's path so that it points away from that way.
    // The way index is left-aligned so that its MSB always picks the root's branch.
    function automatic logic [14:0] plru_update(input logic [14:0] bits, input logic [3:0] way,
                                                input int lvls);
        logic [14:0] r;
        logic [3:0]  al;
        logic [3:0]  node;
        r    = bits;
        al   = way << (PLRU_MAX_LVLS - lvls);
        node = '0;
        for (int l = 0; l < PLRU_MAX_LVLS; l++)
            if (l < lvls) begin
                r[node] = ~al[3-l];
                node    = {node[2:0], 1'b0} + 4'd1 + {3'b0, al[3-l]};
            end
        return r;
    endfunction

endpackage

// File: rtl/param_cache_control_plru_tree.sv
// plru_tree: tree-PLRU update for an accessed way, plus the PLRU victim.
// Ports: plru_in (current node bits), way (accessed way),
// plru_out (updated node bits), victim (way reached by the PLRU walk).
module plru_tree
    import lc3b_types::*;
#(
    parameter int WAYS = 4
) (
    input  logic [WAYS-2:0]         plru_in,
    input  logic [$clog2(WAYS)-1:0] way,
    output logic [WAYS-2:0]         plru_out,
    output logic [$clog2(WAYS)-1:0] victim
);
    localparam int W = $clog2(WAYS);

    assign plru_out = (WAYS-1)'(plru_update(15'(plru_in), 4'(way), W));
    assign victim   = W'(plru_victim(15'(plru_in), W));

endmodule

// File: rtl/param_cache_control.sv
// param_cache_control: set-associative cache controller with tree-PLRU replacement.
// Ports: mem_read/mem_write/mem_resp form the CPU handshake.
// hit_vec/valid_vec/dirty_vec/plru_in carry the state of the indexed set.
// way_sel/load_*/valid_in/dirty_in/data_in_sel/addr_sel/plru_out/load_plru steer the arrays.
// pmem_read/pmem_write/pmem_resp form the backing-memory handshake.
module param_cache_control
    import lc3b_types::*;
#(
    parameter int WAYS        = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int WB_ENABLE   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mem_read,
    input  logic                    mem_write,
    output logic                    mem_resp,
    input  logic [WAYS-1:0]         hit_vec,
    input  logic [WAYS-1:0]         valid_vec,
    input  logic [WAYS-1:0]         dirty_vec,
    input  logic [WAYS-2:0]         plru_in,
    output logic [WAYS-2:0]         plru_out,
    output logic                    load_plru,
    output logic [$clog2(WAYS)-1:0] way_sel,
    output logic [WAYS-1:0]         load_data,
    output logic [WAYS-1:0]         load_tag,
    output logic                    valid_in,
    output logic                    dirty_in,
    output logic                    data_in_sel,
    output logic                    addr_sel,
    output logic                    pmem_read,
    output logic                    pmem_write,
    input  logic                    pmem_resp
);
    localparam int W = $clog2(WAYS);
    localparam logic WB = WB_ENABLE != 0;
    localparam logic [WAYS-1:0] ONE = WAYS'(1);
    localparam cache_state_t AFTER_HIT = (HOLD_CYCLES == 0) ? IDLE : HOLD;

    cache_state_t    state, state_n;
    logic [W-1:0]    victim, hit_idx, inv_idx, plru_vic, pick;
    logic [WAYS-2:0] plru_upd;
    logic [2:0]      hold_cnt;
    logic            req, hit_one, miss;

    assign req     = mem_read ^ mem_write;
    assign hit_one = $onehot(hit_vec);
    assign miss    = hit_vec == '0;
    assign pick    = &valid_vec ? plru_vic : inv_idx;

    always_comb begin
        hit_idx = '0;
        inv_idx = '0;
        for (int i = 0; i < WAYS; i++)
            if (hit_vec[i]) hit_idx = W'(i);
        for (int i = WAYS - 1; i >= 0; i--)
            if (!valid_vec[i]) inv_idx = W'(i);
    end

    plru_tree #(.WAYS(WAYS)) u_plru (
        .plru_in  (plru_in),
        .way      (hit_idx),
        .plru_out (plru_upd),
        .victim   (plru_vic)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            victim   <= '0;
            hold_cnt <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && req && miss) victim <= pick;
            if (state_n == HOLD && state != HOLD) hold_cnt <= 3'(HOLD_CYCLES - 1);
            else if (state == HOLD) hold_cnt <= hold_cnt - 3'd1;
        end
    end

    // Outputs are gated by rst_n so that an asserted reset silences the pmem strobes and the
    // array writes at once, without waiting for a clock edge.
    always_comb begin
        state_n     = state;
        mem_resp    = 1'b0;
        plru_out    = plru_in;
        load_plru   = 1'b0;
        way_sel     = '0;
        load_data   = '0;
        load_tag    = '0;
        valid_in    = 1'b0;
        dirty_in    = 1'b0;
        data_in_sel = 1'b0;
        addr_sel    = 1'b0;
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (req && hit_one) begin
                        way_sel   = hit_idx;
                        load_plru = 1'b1;
                        plru_out  = plru_upd;
                        mem_resp  = !(mem_write && !WB);
                        load_data = mem_write ? ONE << hit_idx : '0;
                        load_tag  = (mem_write && WB) ? ONE << hit_idx : '0;
                        valid_in  = mem_write && WB;
                        dirty_in  = mem_write && WB;
                        state_n   = (mem_write && !WB) ? WRITE_THRU : AFTER_HIT;
                    end else if (req && miss) begin
                        state_n = (valid_vec[pick] && dirty_vec[pick] && WB) ? WRITE_BACK : FETCH;
                    end
                end
                HOLD: state_n = (hold_cnt == 3'd0) ? IDLE : HOLD;
                WRITE_BACK: begin
                    pmem_write = 1'b1;
                    addr_sel   = 1'b1;
                    way_sel    = victim;
                    state_n    = pmem_resp ? FETCH : WRITE_BACK;
                end
                FETCH: begin
                    pmem_read   = 1'b1;
                    data_in_sel = 1'b1;
                    way_sel     = victim;
                    load_data   = pmem_resp ? ONE << victim : '0;
                    load_tag    = pmem_resp ? ONE << victim : '0;
                    valid_in    = pmem_resp;
                    state_n     = pmem_resp ? IDLE : FETCH;
                end
                WRITE_THRU: begin
                    pmem_write = 1'b1;
                    mem_resp   = pmem_resp;
                    state_n    = pmem_resp ? AFTER_HIT : WRITE_THRU;
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_param_cache_control.sv
// tb_param_cache_control: scoreboard bench for a write-back and a write-through controller.
module tb_param_cache_control;

    localparam int R_RESP = 0, R_PLRU = 1, R_LPLRU = 2, R_WAY = 3, R_LDATA = 4, R_LTAG = 5;
    localparam int R_VALID = 6, R_DIRTY = 7, R_DSEL = 8, R_ASEL = 9, R_PRD = 10, R_PWR = 11;
    localparam int B_RESP = 12, B_LDATA = 13, B_DIRTY = 14, B_PRD = 15, B_PWR = 16, B_ASEL = 17;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] val;
    } exp_t;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       mem_read, mem_write, b_read, b_write, pmem_resp;
    logic [3:0] hit_vec, valid_vec, dirty_vec;
    logic [2:0] plru_in;

    logic       mem_resp, load_plru, valid_in, dirty_in, data_in_sel, addr_sel, pmem_read, pmem_write;
    logic [2:0] plru_out;
    logic [1:0] way_sel;
    logic [3:0] load_data, load_tag;

    logic       b_mem_resp, b_load_plru, b_valid_in, b_dirty_in, b_data_in_sel, b_addr_sel;
    logic       b_pmem_read, b_pmem_write;
    logic [2:0] b_plru_out;
    logic [1:0] b_way_sel;
    logic [3:0] b_load_data, b_load_tag;

    int   checks = 0, passed = 0;
    exp_t sb[$];

    param_cache_control #(.WAYS(4), .HOLD_CYCLES(2), .WB_ENABLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec), .plru_in(plru_in),
        .plru_out(plru_out), .load_plru(load_plru), .way_sel(way_sel), .load_data(load_data),
        .load_tag(load_tag), .valid_in(valid_in), .dirty_in(dirty_in), .data_in_sel(data_in_sel),
        .addr_sel(addr_sel), .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp)
    );

    param_cache_control #(.WAYS(4), .HOLD_CYCLES(2), .WB_ENABLE(0)) dut_wt (
        .clk(clk), .rst_n(rst_n), .mem_read(b_read), .mem_write(b_write), .mem_resp(b_mem_resp),
        .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec), .plru_in(plru_in),
        .plru_out(b_plru_out), .load_plru(b_load_plru), .way_sel(b_way_sel), .load_data(b_load_data),
        .load_tag(b_load_tag), .valid_in(b_valid_in), .dirty_in(b_dirty_in),
        .data_in_sel(b_data_in_sel), .addr_sel(b_addr_sel), .pmem_read(b_pmem_read),
        .pmem_write(b_pmem_write), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] obs(input int s);
        case (s)
            R_RESP:  return 32'(mem_resp);
            R_PLRU:  return 32'(plru_out);
            R_LPLRU: return 32'(load_plru);
            R_WAY:   return 32'(way_sel);
            R_LDATA: return 32'(load_data);
            R_LTAG:  return 32'(load_tag);
            R_VALID: return 32'(valid_in);
            R_DIRTY: return 32'(dirty_in);
            R_DSEL:  return 32'(data_in_sel);
            R_ASEL:  return 32'(addr_sel);
            R_PRD:   return 32'(pmem_read);
            R_PWR:   return 32'(pmem_write);
            B_RESP:  return 32'(b_mem_resp);
            B_LDATA: return 32'(b_load_data);
            B_DIRTY: return 32'(b_dirty_in);
            B_PRD:   return 32'(b_pmem_read);
            B_PWR:   return 32'(b_pmem_write);
            B_ASEL:  return 32'(b_addr_sel);
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    endtask

    task automatic want(input string tag, input int sig, input logic [31:0] val);
        sb.push_back('{tag, sig, val});
    endtask

    task automatic settle();
        #1;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check(e.tag, obs(e.sig), e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [3:0] hit, input logic [3:0] valid,
                         input logic [3:0] dirty, input logic [2:0] plru);
        check("hit_onehot", 32'($countones(hit) <= 1), 32'd1);
        mem_read  = r;
        mem_write = w;
        hit_vec   = hit;
        valid_vec = valid;
        dirty_vec = dirty;
        plru_in   = plru;
    endtask

    task automatic quiesce();
        {mem_read, mem_write, b_read, b_write, pmem_resp} = '0;
        hit_vec = '0;
        repeat (4) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: no summary after 100000 time units");
        $fatal(1);
    end

    initial begin
        {mem_read, mem_write, b_read, b_write, pmem_resp} = '0;
        dirty_vec = '0;
        drive(1'b1, 1'b0, 4'b0001, 4'hf, 4'h0, 3'b101);
        b_read = 1'b1;
        #3;
        want("rst_resp", R_RESP, 0); want("rst_plru", R_PLRU, 3'b101); want("rst_lplru", R_LPLRU, 0);
        want("rst_ldata", R_LDATA, 0); want("rst_b_resp", B_RESP, 0);
        settle();
        repeat (2) tick();
        rst_n = 1'b1;
        quiesce();

        drive(1'b1, 1'b0, 4'b0001, 4'hf, 4'h0, 3'b000);
        want("hit0_resp", R_RESP, 1); want("hit0_plru", R_PLRU, 3'b011);
        want("hit0_lplru", R_LPLRU, 1); want("hit0_way", R_WAY, 0); want("hit0_ldata", R_LDATA, 0);
        settle();
        tick(); want("hold1_resp", R_RESP, 0); want("hold1_lplru", R_LPLRU, 0); settle();
        tick(); want("hold2_resp", R_RESP, 0); settle();
        tick(); want("post_hold_resp", R_RESP, 1); settle();
        quiesce();

        drive(1'b1, 1'b0, 4'b0100, 4'hf, 4'h0, 3'b000);
        want("hit2_resp", R_RESP, 1); want("hit2_plru", R_PLRU, 3'b100); want("hit2_way", R_WAY, 2);
        settle();
        quiesce();

        drive(1'b0, 1'b1, 4'b1000, 4'hf, 4'h0, 3'b111);
        want("whit_resp", R_RESP, 1); want("whit_plru", R_PLRU, 3'b010); want("whit_ldata", R_LDATA, 4'b1000);
        want("whit_ltag", R_LTAG, 4'b1000); want("whit_dirty", R_DIRTY, 1); want("whit_pwr", R_PWR, 0);
        settle();
        quiesce();

        drive(1'b1, 1'b1, 4'b0001, 4'hf, 4'h0, 3'b000);
        want("both_resp", R_RESP, 0); want("both_lplru", R_LPLRU, 0); want("both_ldata", R_LDATA, 0);
        settle();
        tick(); want("both_prd", R_PRD, 0); want("both_pwr", R_PWR, 0); want("both_resp2", R_RESP, 0);
        settle();
        quiesce();

        drive(1'b1, 1'b0, 4'b0000, 4'hf, 4'h0, 3'b000);
        want("rmiss_resp", R_RESP, 0); want("rmiss_prd0", R_PRD, 0); settle();
        tick();
        want("fetch_prd", R_PRD, 1); want("fetch_dsel", R_DSEL, 1); want("fetch_asel", R_ASEL, 0);
        want("fetch_way", R_WAY, 0); want("fetch_ltag", R_LTAG, 0);
        settle();
        repeat (4) begin
            tick(); want("fetch_wait_prd", R_PRD, 1); want("fetch_wait_ltag", R_LTAG, 0); settle();
        end
        tick();
        pmem_resp = 1'b1;
        want("fill_ltag", R_LTAG, 4'b0001); want("fill_ldata", R_LDATA, 4'b0001);
        want("fill_valid", R_VALID, 1); want("fill_dirty", R_DIRTY, 0); want("fill_resp", R_RESP, 0);
        settle();
        tick();
        pmem_resp = 1'b0;
        hit_vec   = 4'b0001;
        want("reissue_resp", R_RESP, 1); want("reissue_prd", R_PRD, 0); settle();
        quiesce();

        drive(1'b0, 1'b1, 4'b0000, 4'hf, 4'b0100, 3'b011);
        want("wmiss_resp", R_RESP, 0); settle();
        tick();
        want("wb_pwr", R_PWR, 1); want("wb_asel", R_ASEL, 1); want("wb_way", R_WAY, 2); want("wb_prd", R_PRD, 0);
        settle();
        tick();
        pmem_resp = 1'b1;
        want("wb_resp_pwr", R_PWR, 1); want("wb_resp_ldata", R_LDATA, 0); settle();
        tick();
        pmem_resp = 1'b0;
        mem_write = 1'b0;
        want("wbf_prd", R_PRD, 1); want("wbf_pwr", R_PWR, 0); want("wbf_way", R_WAY, 2);
        want("wbf_asel", R_ASEL, 0);
        settle();
        tick(); want("drop_held_prd", R_PRD, 1); settle();
        pmem_resp = 1'b1;
        want("wbf_ldata", R_LDATA, 4'b0100); want("wbf_ltag", R_LTAG, 4'b0100); want("wbf_valid", R_VALID, 1);
        settle();
        tick();
        quiesce();

        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b1, 4'b0000, 4'b1011, 4'hf, (k == 0) ? 3'b000 : 3'b111);
            tick();
            want("inv_prd", R_PRD, 1); want("inv_pwr", R_PWR, 0); want("inv_way", R_WAY, 2); settle();
            pmem_resp = 1'b1;
            want("inv_ltag", R_LTAG, 4'b0100); settle();
            tick();
            quiesce();
        end

        drive(1'b1, 1'b0, 4'b0000, 4'hf, 4'h0, 3'b000);
        tick();
        want("prerst_prd", R_PRD, 1); settle();
        pmem_resp = 1'b1;
        rst_n     = 1'b0;
        want("rst_fetch_prd", R_PRD, 0); want("rst_fetch_ldata", R_LDATA, 0);
        want("rst_fetch_ltag", R_LTAG, 0); want("rst_fetch_valid", R_VALID, 0);
        settle();
        tick();
        rst_n     = 1'b1;
        pmem_resp = 1'b0;
        mem_read  = 1'b0;
        tick();
        want("post_rst_prd", R_PRD, 0); settle();
        hit_vec  = 4'b0001;
        mem_read = 1'b1;
        want("post_rst_hit", R_RESP, 1); settle();
        quiesce();

        hit_vec = 4'b0010; valid_vec = 4'hf; dirty_vec = 4'h0; plru_in = 3'b000;
        b_write = 1'b1;
        want("wt_resp", B_RESP, 0); want("wt_ldata", B_LDATA, 4'b0010); want("wt_dirty", B_DIRTY, 0);
        want("wt_pwr0", B_PWR, 0);
        settle();
        tick(); want("wt_pwr", B_PWR, 1); want("wt_asel", B_ASEL, 0); want("wt_wait_resp", B_RESP, 0); settle();
        tick();
        pmem_resp = 1'b1;
        want("wt_done_resp", B_RESP, 1); want("wt_done_pwr", B_PWR, 1); settle();
        tick();
        pmem_resp = 1'b0;
        want("wt_hold_pwr", B_PWR, 0); want("wt_hold_resp", B_RESP, 0); settle();
        quiesce();

        b_read = 1'b1; b_write = 1'b1; hit_vec = 4'b0010;
        want("wt_both_resp", B_RESP, 0); want("wt_both_ldata", B_LDATA, 0); settle();
        tick(); want("wt_both_pwr", B_PWR, 0); settle();
        quiesce();

        b_write = 1'b1; hit_vec = 4'b0000; valid_vec = 4'hf; dirty_vec = 4'hf; plru_in = 3'b011;
        tick();
        want("wt_miss_prd", B_PRD, 1); want("wt_miss_pwr", B_PWR, 0); settle();
        pmem_resp = 1'b1;
        want("wt_fill_ldata", B_LDATA, 4'b0100); settle();
        tick();
        quiesce();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
